frame_fifo_controller: RTL
==========================

# frame_fifo_controller

Single-clock store-and-forward controller for the switch's per-port frame FIFO. It accepts a byte stream from the MAC receive path, writes bytes plus an end-of-frame flag into the 1024 x 9 LSRAM frame buffer, and commits each frame only when it ends without error. It reads committed frames back out to the forwarding stage through a valid/ready stream. Errored or overflowing frames are rolled back and never reach the output.

## Interface
- DEPTH, 1024: RAM words; power of two.
- ADDR_W, 10: log2(DEPTH).
- CNT_W, 16: drop counter width.

Ports:
- clock  in  1  single clock for all logic and both RAM ports.
- reset_n  in  1  reset; asynchronous, active-low.
- s_data  in  8  ingress byte.
- s_valid  in  1  byte present. No backpressure; the MAC cannot stall.
- s_last  in  1  final byte of frame; qualified by s_valid.
- s_error  in  1  frame bad (FCS/runt); sampled only with s_valid & s_last.
- ram_wd  out  9  {last, data} to RAM write port.
- ram_waddr  out  ADDR_W  write address.
- ram_wen  out  1  write strobe, active-high.
- ram_raddr  out  ADDR_W  read address.
- ram_ren  out  1  read strobe, active-high. ram_rd is valid on the cycle after the edge that samples it.
- ram_rd  in  9  read data {last, data}.
- m_data  out  8  egress byte.
- m_valid  out  1  egress byte present.
- m_last  out  1  egress end of frame.
- m_ready  in  1  downstream accepts.
- frame_count  out  ADDR_W+1  committed frames not yet fully read out.
- drop_count  out  CNT_W  frames dropped; saturates at all-ones.
- drop_pulse  out  1  one-cycle pulse per dropped frame.

## Operation
- Pointers: wr_ptr (speculative), commit_ptr, and rd_ptr. Each is ADDR_W+1 bits, and the MSB is the wrap bit. Address = low ADDR_W bits.
- Write side:
  - An accepted byte is registered into ram_wd/ram_waddr/ram_wen for one cycle; wr_ptr increments at the same edge.
  - Space check: full when wr_ptr − rd_ptr == DEPTH. The check includes the in-flight registered write.
- Write FSM: IDLE, RECV, DISCARD.
  - IDLE → RECV on a first byte with space.
  - RECV → IDLE on an accepted last byte, or on an errored last byte (rollback).
  - RECV → DISCARD when a byte arrives while full; wr_ptr ← commit_ptr.
  - DISCARD → IDLE on s_last; no writes are performed in DISCARD.
  - A first byte arriving while full enters DISCARD directly. A single-byte frame (s_last on the first byte) goes IDLE → IDLE.
- Commit: a good last byte sets commit_ptr ← wr_ptr (post-increment) on the edge its RAM write occurs, and increments frame_count.
- Rollback: an errored last byte is not written; wr_ptr ← commit_ptr.
- Drop accounting: each rollback or DISCARD entry raises drop_pulse and increments drop_count (saturating). This is exactly once per frame.
- Read side:
  - A read is issued when rd_ptr != commit_ptr and (buffer occupancy + reads in flight) < 2; rd_ptr increments.
  - ram_rd is captured into a 2-entry output buffer whose head drives m_data, m_last and m_valid.
  - A head transfer with m_last decrements frame_count.
- Simultaneous commit and last-byte read in one cycle: frame_count holds.
- Reset: all pointers 0, FSM IDLE, buffer empty. m_valid, ram_wen, ram_ren, drop_pulse, frame_count, drop_count, ram_wd, ram_waddr and ram_raddr are all 0.

## Timing
- Ingress byte accepted at edge E0: RAM write at E1.
- For a good last byte accepted at E0: commit at E1.
- Empty FIFO: m_valid rises after edge E3 following last-byte acceptance at E0. Path: ram_ren sampled at E2, data captured at E3.
- Sustained throughput: one byte/clock in, one byte/clock out with m_ready held high. No read bubbles after the first byte.
- m_data/m_last hold stable while m_valid & !m_ready.
- Reset mid-frame discards all contents. No partial frame is ever emitted after reset.

## Structure
- Shared package `frame_fifo_pkg`:
  - write FSM state enum;
  - DEPTH/ADDR_W constants;
  - localparam bit indices LAST_BIT = 8 and DATA_MSB = 7.
- Sub-module `frame_fifo_out_buf`: 2-entry valid/ready skid buffer taking RAM read data plus the in-flight count. It reports credit back to the read-issue logic.
- The RAM is instantiated by the parent wrapper, not inside this block.

## Test plan
- 64-byte good frame, m_ready=1:
  - m_valid rises 3 edges after the last byte is accepted;
  - 64 bytes out in 64 consecutive cycles, m_last on byte 64;
  - frame_count goes 1 → 0.
- 100-byte frame with s_error on its last byte, then a 20-byte good frame:
  - only the 20-byte frame is emitted;
  - drop_count=1, one drop_pulse;
  - commit_ptr advances by 20 only.
- m_ready low with 3 good 300-byte frames in:
  - frames 1–3 are stored (900 words);
  - a 4th 300-byte frame exceeds DEPTH, enters DISCARD and is dropped (drop_count=1);
  - after m_ready=1 exactly 900 bytes are emitted in order.
- Single-byte frame:
  - 1 byte out with m_last=1;
  - frame_count pulses 1 → 0.
- Random m_ready toggling across 50 random-length frames (1–600 bytes):
  - output matches the scoreboard byte-exact;
  - m_data stable while stalled.
- reset_n asserted mid-frame and mid-readout:
  - all outputs 0 immediately;
  - after release, the next good frame is emitted cleanly from address 0.

Source files
------------

// File: rtl/frame_fifo_pkg.sv
// rtl/frame_fifo_pkg.sv - shared constants and write FSM state type for the frame FIFO controller
//
// Contents:
//   DEPTH, ADDR_W, CNT_W   default buffer geometry and drop counter width
//   LAST_BIT, DATA_MSB     field positions inside a 9-bit {last, data} RAM word
//   wr_state_t             ingress FSM state encoding
package frame_fifo_pkg;

    localparam int DEPTH    = 1024;
    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 16;
    localparam int LAST_BIT = 8;
    localparam int DATA_MSB = 7;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_RECV    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/frame_fifo_out_buf.sv
// rtl/frame_fifo_out_buf.sv - 2-entry egress skid buffer fed by the frame RAM read port
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   issue               a RAM read is sampled on this edge; its data arrives next cycle
//   rd_data[8:0]        RAM read data {last, data}
//   credit              another read may be issued this cycle without overflowing
//   m_data, m_last      head entry of the buffer
//   m_valid, m_ready    egress handshake
module frame_fifo_out_buf
    import frame_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       issue,
    input  logic [8:0] rd_data,
    output logic       credit,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready
);

    logic [8:0] ent0;
    logic [8:0] ent1;
    logic [1:0] count;
    logic       inflight;
    logic       pop;
    logic       push;
    logic [2:0] level;

    assign m_valid = (count != 2'd0);
    assign m_data  = ent0[DATA_MSB:0];
    assign m_last  = ent0[LAST_BIT];
    assign pop     = m_valid & m_ready;
    assign push    = inflight;

    // Occupancy after this cycle's pop plus the read already travelling
    // through the RAM; counting the pop keeps reads back-to-back while the
    // consumer drains one byte per clock.
    assign level  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign credit = (level < 3'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ent0     <= '0;
            ent1     <= '0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (push && pop) begin
                if (count == 2'd2) begin
                    ent0 <= ent1;
                    ent1 <= rd_data;
                end else begin
                    ent0 <= rd_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    ent0 <= rd_data;
                end else begin
                    ent1 <= rd_data;
                end
                count <= count + 2'd1;
            end else if (pop) begin
                ent0  <= ent1;
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/frame_fifo_controller.sv
// rtl/frame_fifo_controller.sv - store-and-forward frame FIFO controller for an external 1024x9 RAM
//
// Ports:
//   clock, reset_n                    clock and asynchronous active-low reset
//   s_data, s_valid, s_last, s_error  ingress byte stream (no backpressure)
//   ram_wd, ram_waddr, ram_wen        RAM write port, {last, data} words
//   ram_raddr, ram_ren, ram_rd        RAM read port, data one cycle after the sampling edge
//   m_data, m_valid, m_last, m_ready  egress stream of committed frames
//   frame_count                       committed frames not yet fully read out
//   drop_count, drop_pulse            dropped frame counter (saturating) and per-drop pulse
module frame_fifo_controller
    import frame_fifo_pkg::*;
#(
    parameter int DEPTH  = frame_fifo_pkg::DEPTH,
    parameter int ADDR_W = frame_fifo_pkg::ADDR_W,
    parameter int CNT_W  = frame_fifo_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic              s_error,
    output logic [8:0]        ram_wd,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_ren,
    input  logic [8:0]        ram_rd,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W:0]   frame_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              drop_pulse
);

    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DROP_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

    wr_state_t       state;
    wr_state_t       state_next;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] frame_start;
    logic [ADDR_W:0] commit_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            commit_pend;

    logic            full;
    logic            do_write;
    logic            good_last;
    logic            rollback;
    logic            drop_evt;

    logic            credit;
    logic            last_pop;

    // wr_ptr already counts the byte sitting in the write register, so
    // the in-flight write is part of the occupancy seen here.
    assign full = ((wr_ptr - rd_ptr) == FULL_LVL);

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        good_last  = 1'b0;
        rollback   = 1'b0;
        drop_evt   = 1'b0;
        if (s_valid) begin
            case (state)
                WR_IDLE, WR_RECV: begin
                    if (s_last && s_error) begin
                        rollback   = 1'b1;
                        drop_evt   = 1'b1;
                        state_next = WR_IDLE;
                    end else if (full) begin
                        rollback   = 1'b1;
                        drop_evt   = 1'b1;
                        state_next = s_last ? WR_IDLE : WR_DISCARD;
                    end else begin
                        do_write = 1'b1;
                        if (s_last) begin
                            good_last  = 1'b1;
                            state_next = WR_IDLE;
                        end else begin
                            state_next = WR_RECV;
                        end
                    end
                end
                WR_DISCARD: begin
                    if (s_last) begin
                        state_next = WR_IDLE;
                    end
                end
                default: state_next = WR_IDLE;
            endcase
        end
    end

    // frame_start tracks the committed end as soon as a good last byte is
    // accepted, so a rollback on the very next cycle lands in the right place.
    // commit_ptr is its one-edge-delayed copy and only becomes visible to the
    // read side on the edge the last byte is written into the RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WR_IDLE;
            wr_ptr      <= '0;
            frame_start <= '0;
            commit_ptr  <= '0;
            commit_pend <= 1'b0;
            ram_wd      <= '0;
            ram_waddr   <= '0;
            ram_wen     <= 1'b0;
            drop_pulse  <= 1'b0;
            drop_count  <= '0;
        end else begin
            state       <= state_next;
            ram_wen     <= do_write;
            commit_ptr  <= frame_start;
            commit_pend <= good_last;
            drop_pulse  <= drop_evt;
            if (do_write) begin
                ram_wd[LAST_BIT]     <= s_last;
                ram_wd[DATA_MSB:0]   <= s_data;
                ram_waddr            <= wr_ptr[ADDR_W-1:0];
            end
            if (rollback) begin
                wr_ptr <= frame_start;
            end else if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (good_last) begin
                frame_start <= wr_ptr + PTR_ONE;
            end
            if (drop_evt && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + DROP_ONE;
            end
        end
    end

    assign ram_ren   = (rd_ptr != commit_ptr) && credit;
    assign ram_raddr = rd_ptr[ADDR_W-1:0];
    assign last_pop  = m_valid && m_ready && m_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            frame_count <= '0;
        end else begin
            if (ram_ren) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (commit_pend && !last_pop) begin
                frame_count <= frame_count + PTR_ONE;
            end else if (!commit_pend && last_pop) begin
                frame_count <= frame_count - PTR_ONE;
            end
        end
    end

    frame_fifo_out_buf u_out_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .issue   (ram_ren),
        .rd_data (ram_rd),
        .credit  (credit),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

endmodule
